// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and op classification for alu_seq (honours ALU_MULDIV_EN)
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Multi-cycle ops exist only when the iterative mul/div unit is built;
    // otherwise those opcodes fall through to the illegal single-cycle path.
    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op != op);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiplier / restoring divider, built only with ALU_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int CW = $clog2(WIDTH + 1);

    // acc holds {partial product, multiplier} or {remainder, quotient/dividend}
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   opnd_q;
    logic [3:0]         op_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;

    // One multiply or divide step computed from the current accumulator
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
        mul_next = {sum, acc_q[WIDTH-1:1]};
        trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (trial[WIDTH]) begin
            div_next = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        acc_d = op_q[2] ? div_next : mul_next;
    end

    // The last step is taken on the same edge the top captures res, so res
    // is read from the step output rather than the accumulator register.
    always_comb begin
        res = '0;
        case (op_q)
            OP_MUL:   res = mul_next[WIDTH-1:0];
            OP_MULHU: res = mul_next[2*WIDTH-1:WIDTH];
            OP_DIVU:  res = div_next[WIDTH-1:0];
            OP_REMU:  res = div_next[2*WIDTH-1:WIDTH];
            default:  res = '0;
        endcase
    end

    assign done = (cnt_q == CW'(1));

    // Load operands on start, then one step per cycle until the count expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            acc_q  <= {{WIDTH{1'b0}}, (op[2] ? a : b)};
            opnd_q <= op[2] ? b : a;
            op_q   <= op;
            cnt_q  <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU top: FSM, single-cycle unit, output registers; ALU_MULDIV_EN adds mul/div
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sc_res;
    logic             sc_illegal;
    logic [SHW-1:0]   shamt;
    logic             sc_load;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    // Single-cycle datapath straight off the input bundle; the result is
    // registered on the accept edge, which is the operand latch.
    always_comb begin
        sc_res     = '0;
        sc_illegal = 1'b0;
        shamt      = bus.b[SHW-1:0];
        case (bus.op)
            OP_ADD:  sc_res = bus.a + bus.b;
            OP_SUB:  sc_res = bus.a - bus.b;
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_SLL:  sc_res = bus.a << shamt;
            OP_SRL:  sc_res = bus.a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(bus.a) >>> shamt);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: sc_illegal = 1'b1;
        endcase
    end

    assign sc_load = (state_q == S_IDLE) && bus.in_valid && !is_multicycle(bus.op);

`ifdef ALU_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic             md_load;
    logic [WIDTH-1:0] md_res;

    assign md_start = (state_q == S_IDLE) && bus.in_valid && is_multicycle(bus.op);
    assign md_load  = (state_q == S_BUSY) && md_done;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (bus.op),
        .a     (bus.a),
        .b     (bus.b),
        .done  (md_done),
        .res   (md_res)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in_valid is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = is_multicycle(bus.op) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
`ifdef ALU_MULDIV_EN
                if (md_done) begin
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers: loaded once per op, held unchanged through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (sc_load) begin
            result_q  <= sc_res;
            zero_q    <= (sc_res == '0);
            illegal_q <= sc_illegal;
        end
`ifdef ALU_MULDIV_EN
        else if (md_load) begin
            result_q  <= md_res;
            zero_q    <= (md_res == '0);
            illegal_q <= 1'b0;
        end
`endif
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=16 (expectations follow ALU_MULDIV_EN)
module tb_alu_seq;
    import alu_pkg::*;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = OP_ADD;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
    endtask

    task automatic wait_valid(output int lat, output int rdy_hi);
        lat    = 1;
        rdy_hi = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_hi++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op       = 4'h0;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.result !== 16'h0) begin failures++; $display("FAIL reset_result got=%h exp=0000", bus.result); end
        checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_wrap();
        int lat;
        int rdy;
        send(OP_ADD, 16'hFFFF, 16'h0001);
        wait_valid(lat, rdy);
        checks++; if (lat != 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if (bus.result !== 16'h0000) begin failures++; $display("FAIL add_result got=%h exp=0000", bus.result); end
        checks++; if (bus.zero !== 1'b1) begin failures++; $display("FAIL add_zero got=%b exp=1", bus.zero); end
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL add_illegal got=%b exp=0", bus.illegal); end
        pop();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL add_release out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_single_cycle_ops();
        logic [3:0]  v_op  [0:9];
        logic [15:0] v_a   [0:9];
        logic [15:0] v_b   [0:9];
        logic [15:0] v_exp [0:9];
        logic        v_ill [0:9];
        int lat;
        int rdy;
        v_op  = '{OP_SUB,   OP_AND,   OP_OR,    OP_XOR,   OP_SLL,   OP_SRL,   OP_SRA,   OP_SLT,   OP_SLTU,  4'b1110};
        v_a   = '{16'h0005, 16'hF0F0, 16'h00F0, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h1234};
        v_b   = '{16'h0007, 16'hFF00, 16'h0F00, 16'h00FF, 16'h0013, 16'h001F, 16'h000F, 16'h0001, 16'h0001, 16'h5678};
        v_exp = '{16'hFFFE, 16'hF000, 16'h0FF0, 16'hFF00, 16'h0008, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
        v_ill = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1};
        for (int i = 0; i < 10; i++) begin
            send(v_op[i], v_a[i], v_b[i]);
            wait_valid(lat, rdy);
            checks++; if (lat != 1) begin failures++; $display("FAIL sc_latency[%0d] got=%0d exp=1", i, lat); end
            checks++; if (bus.result !== v_exp[i] || bus.illegal !== v_ill[i] || bus.zero !== (v_exp[i] == 16'h0)) begin
                failures++;
                $display("FAIL sc_result[%0d] op=%b got=%h/ill=%b/z=%b exp=%h/ill=%b/z=%b",
                         i, v_op[i], bus.result, bus.illegal, bus.zero, v_exp[i], v_ill[i], (v_exp[i] == 16'h0));
            end
            pop();
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  v_op  [0:5];
        logic [15:0] v_a   [0:5];
        logic [15:0] v_b   [0:5];
        logic [15:0] v_exp [0:5];
        logic [15:0] exp_res;
        int exp_lat;
        int lat;
        int rdy;
        v_op  = '{OP_MUL,   OP_MULHU, OP_DIVU,  OP_REMU,  OP_DIVU,  OP_REMU};
        v_a   = '{16'd300,  16'd300,  16'd100,  16'd100,  16'd5,    16'd5};
        v_b   = '{16'd300,  16'd300,  16'd7,    16'd7,    16'd0,    16'd0};
        v_exp = '{16'h5F90, 16'h0001, 16'd14,   16'd2,    16'hFFFF, 16'd5};
        exp_lat = MD ? 17 : 1;
        for (int i = 0; i < 6; i++) begin
            exp_res = MD ? v_exp[i] : 16'h0000;
            send(v_op[i], v_a[i], v_b[i]);
            wait_valid(lat, rdy);
            checks++; if (lat != exp_lat) begin failures++; $display("FAIL md_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
            checks++; if (rdy != 0) begin failures++; $display("FAIL md_in_ready_busy[%0d] high_cycles=%0d exp=0", i, rdy); end
            checks++; if (bus.result !== exp_res || bus.illegal !== !MD || bus.zero !== (exp_res == 16'h0)) begin
                failures++;
                $display("FAIL md_result[%0d] op=%b got=%h/ill=%b/z=%b exp=%h/ill=%b/z=%b",
                         i, v_op[i], bus.result, bus.illegal, bus.zero, exp_res, !MD, (exp_res == 16'h0));
            end
            pop();
        end
    endtask

    task automatic test_hold();
        int lat;
        int rdy;
        int bad;
        send(OP_ADD, 16'h1234, 16'h0001);
        wait_valid(lat, rdy);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.result !== 16'h1235 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.zero !== 1'b0) bad++;
            bus.in_valid = (c == 3);
            bus.op       = OP_SUB;
            bus.a        = 16'h0009;
            bus.b        = 16'h0001;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
        checks++; if (bus.result !== 16'h1235) begin failures++; $display("FAIL hold_result got=%h exp=1235", bus.result); end
        pop();
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
            @(posedge clk);
            #1;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_no_extra_accept bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int rdy;
        send(OP_MUL, 16'd300, 16'd300);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_result got=%b exp=0", bus.out_valid); end
        send(4'b1111, 16'hAAAA, 16'h5555);
        wait_valid(lat, rdy);
        checks++; if (lat != 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
        checks++; if (bus.illegal !== 1'b1 || bus.result !== 16'h0 || bus.zero !== 1'b1) begin
            failures++;
            $display("FAIL illegal_result got=%h/ill=%b/z=%b exp=0000/ill=1/z=1", bus.result, bus.illegal, bus.zero);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int lat;
        int rdy;
        bus.out_ready = 1'b1;
        send(OP_OR, 16'h0A00, 16'h00B0);
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 16'h0AB0) begin
            failures++; $display("FAIL b2b_first valid=%b result=%h exp 1/0ab0", bus.out_valid, bus.result);
        end
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_idle in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b0;
        send(OP_SUB, 16'h0000, 16'h0001);
        wait_valid(lat, rdy);
        checks++; if (lat != 1 || bus.result !== 16'hFFFF) begin
            failures++; $display("FAIL b2b_second lat=%0d result=%h exp 1/ffff", lat, bus.result);
        end
        pop();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add_wrap();
        test_single_cycle_ops();
        test_muldiv();
        test_hold();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
